// File: rtl/prim_dev_host_if.sv
// Bundle of request-side and device-side signals for the primitive device host.
// The master modport is the environment (button/CPU side plus the device);
// the slave modport is the host controller itself.
interface prim_dev_host_if #(
  parameter int SW_W   = 3,
  parameter int DATA_W = 32
);
  // request side
  logic              start_i;
  logic [SW_W-1:0]   sw_i;
  logic [DATA_W-1:0] result_o;
  logic              valid_o;
  logic              busy_o;
  logic              timeout_o;
  // device side
  logic              dev_en_o;
  logic [SW_W-1:0]   dev_sw_o;
  logic [DATA_W-1:0] dev_result_i;
  logic              dev_done_i;

  modport master (
    output start_i, sw_i, dev_result_i, dev_done_i,
    input  result_o, valid_o, busy_o, timeout_o, dev_en_o, dev_sw_o
  );

  modport slave (
    input  start_i, sw_i, dev_result_i, dev_done_i,
    output result_o, valid_o, busy_o, timeout_o, dev_en_o, dev_sw_o
  );
endinterface

// File: rtl/prim_dev_host.sv
// Initiator-side controller for the primitive compute device.
// A rising edge on start launches a request: the operand select is latched,
// the device enable is held high, and the first fresh rising edge of the
// device done line captures the result. A request with no completion within
// TIMEOUT cycles is aborted and flagged with a sticky timeout bit.
module prim_dev_host #(
  parameter int SW_W    = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  prim_dev_host_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              start_q_r;
  logic              done_q_r;
  logic              dev_en_r, dev_en_s;
  logic [SW_W-1:0]   dev_sw_r, dev_sw_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              timeout_r, timeout_s;
  logic              start_edge_s;
  logic              done_edge_s;

  // Edge detection; done_q follows the line every cycle so a level that is
  // already high on REQ entry never looks like a completion.
  assign start_edge_s = bus.start_i & ~start_q_r;
  assign done_edge_s  = bus.dev_done_i & ~done_q_r;

  // State, counter, edge history and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      start_q_r <= 1'b0;
      done_q_r  <= 1'b0;
      dev_en_r  <= 1'b0;
      dev_sw_r  <= {SW_W{1'b0}};
      result_r  <= {DATA_W{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      start_q_r <= bus.start_i;
      done_q_r  <= bus.dev_done_i;
      dev_en_r  <= dev_en_s;
      dev_sw_r  <= dev_sw_s;
      result_r  <= result_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state and next-output decode; done edge wins over the terminal count.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    dev_en_s  = dev_en_r;
    dev_sw_s  = dev_sw_r;
    result_s  = result_r;
    valid_s   = 1'b0;
    busy_s    = busy_r;
    timeout_s = timeout_r;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_s   = REQ;
          dev_sw_s  = bus.sw_i;
          timeout_s = 1'b0;
          cnt_s     = {CNT_W{1'b0}};
          dev_en_s  = 1'b1;
          busy_s    = 1'b1;
        end else begin
          dev_en_s  = 1'b0;
          busy_s    = 1'b0;
        end
      end
      REQ: begin
        if (done_edge_s) begin
          state_s  = IDLE;
          result_s = bus.dev_result_i;
          valid_s  = 1'b1;
          dev_en_s = 1'b0;
          busy_s   = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
          dev_en_s  = 1'b0;
          busy_s    = 1'b0;
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          dev_en_s = 1'b1;
          busy_s   = 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
        dev_en_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  assign bus.dev_en_o  = dev_en_r;
  assign bus.dev_sw_o  = dev_sw_r;
  assign bus.result_o  = result_r;
  assign bus.valid_o   = valid_r;
  assign bus.busy_o    = busy_r;
  assign bus.timeout_o = timeout_r;

endmodule

// File: doc/prim_dev_host.md
Name: prim_dev_host

Overview:
Initiator-side controller for the primitive compute device, which uses an en/SW/done/HEX handshake. It turns a start request into an enable, holds the operand select stable, and waits for the device's done rising edge. It then captures the 32-bit result and reports valid, busy and timeout status. It sits between top-level buttons/switches (or a CPU register) and the device.

Parameters:
SW_W, 3, width of the operand/mode select driven to the device
DATA_W, 32, width of the device result
TIMEOUT, 1024, number of cycles spent in REQ before the request is aborted (must be >= 2)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
start_i  input  1  request level; a 0->1 transition starts a transaction
sw_i  input  SW_W  operand select, sampled on the start edge
dev_en_o  output  1  enable to device, high for the whole request
dev_sw_o  output  SW_W  latched operand select to device
dev_result_i  input  DATA_W  device result bus
dev_done_i  input  1  device completion level
result_o  output  DATA_W  captured result, held until the next capture
valid_o  output  1  one-cycle pulse when result_o is updated
busy_o  output  1  high while a transaction is outstanding
timeout_o  output  1  sticky abort flag, cleared by the next accepted start

Behaviour:
- Reset (rst_n_i=0, takes effect immediately): state=IDLE; dev_en_o=0, dev_sw_o=0, result_o=0, valid_o=0, busy_o=0, timeout_o=0.
- Edge-detect registers for start_i and dev_done_i reset to 0.
- start_i edge: start_i=1 while start_q=0.
- done edge: dev_done_i=1 while done_q=0.
- All outputs are registered.
- IDLE: on a start edge in cycle N:
  - latch sw_i into dev_sw_o;
  - clear timeout_o;
  - clear the timeout counter;
  - go to REQ.
  - From N+1: dev_en_o=1, busy_o=1.
- REQ: dev_en_o=1, dev_sw_o held stable; the counter increments every cycle.
  - Done edge sampled in cycle M: result_o<=dev_result_i. At M+1: valid_o=1 for exactly one cycle, dev_en_o=0, busy_o=0. Next state is IDLE.
  - Counter reaches TIMEOUT-1 with no done edge: dev_en_o=0, busy_o=0, timeout_o=1 next cycle. Go to IDLE; result_o unchanged; no valid_o.
  - A done edge on the same cycle as the timeout terminal count takes priority: capture, no timeout.
- Stale done: if dev_done_i is already high when REQ is entered, it is not a completion. Capture needs a fresh 0->1 edge during REQ.
- Start edges seen outside IDLE are ignored and not queued. start_i held high does not retrigger; a new transaction needs start_i to return to 0.
- A start edge in the same cycle the FSM returns to IDLE is not accepted; it needs a new edge.
- Changes on sw_i during REQ do not affect dev_sw_o.
- Reset mid-transaction: dev_en_o drops immediately (asynchronous); any in-flight result is discarded.
- Transaction latency from start edge to valid_o: (cycles until done edge) + 2 minimum.

Test Plan:
- Basic: reset, sw_i=3, start pulse; device model asserts done 5 cycles after en with result 0x0000_0006 -> dev_en_o high 1 cycle after start, dev_sw_o=3, result_o=6 with one valid_o pulse 1 cycle after the done edge, busy_o low afterwards.
- Stale done: hold dev_done_i=1 before start, drop it 3 cycles into REQ, raise it 4 cycles later with result 0xDEAD_BEEF -> no capture on entry; capture 0xDEAD_BEEF only after the fresh edge.
- Timeout: TIMEOUT=16, device never asserts done -> dev_en_o drops and timeout_o=1 after exactly 16 REQ cycles; result_o keeps its old value; a next start clears timeout_o.
- Ignored starts / sw stability: toggle start_i and change sw_i to 5 during REQ -> single transaction, dev_sw_o stays 3, exactly one valid_o.
- Async reset mid-REQ: assert rst_n_i between clock edges -> dev_en_o, busy_o and result_o go to 0 before the next edge; a fresh start after release works normally.
- Done at terminal count: TIMEOUT=16, done edge at counter=15 -> capture with valid_o=1 and timeout_o stays 0.
